// File: rtl/fifo_pkg.sv
// Shared FIFO package: pointer-width derivation, the DEPTH power-of-two
// check (also used by the dual-clock FIFO), reset-value constants and the
// per-cycle operation encoding used by the single-clock FIFO control.
package fifo_pkg;

    // Address width for a given depth; a depth of 1 still gets one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // True when depth is a power of two and at least 2.
    function automatic bit is_pow2(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    // Reset values of the single-bit status outputs.
    localparam logic RST_EMPTY = 1'b1;
    localparam logic RST_FULL  = 1'b0;
    localparam logic RST_PULSE = 1'b0;
    localparam logic RST_ERR   = 1'b0;

    // Encoded as {write accepted, read accepted} so it can be cast directly.
    typedef enum logic [1:0] {
        OP_IDLE     = 2'b00,
        OP_POP      = 2'b01,
        OP_PUSH     = 2'b10,
        OP_PUSH_POP = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array for the FIFOs.
// Ports:
//   clk      write clock (rising edge)
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address (asynchronous read)
//   rd_data  read data, combinational from rd_addr
// Contents are not reset.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost-full /
// almost-empty thresholds, synchronous flush and sticky error status.
// Optional macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through read
// data; when undefined, rdata_o is registered on each accepted read.
// Ports:
//   clk_i, res_i            clock (rising edge), async active-high reset
//   wr_en_i, wdata_i        write request and data
//   rd_en_i                 read request (pop in FWFT mode)
//   flush_i                 synchronous flush, overrides wr/rd
//   clr_err_i               clears err_o (a new error in the same cycle wins)
//   af_thresh_i/ae_thresh_i almost-full / almost-empty thresholds
//   rdata_o                 read data
//   full_o, empty_o         registered occupancy flags
//   almost_full_o/_empty_o  count_o >= af_thresh_i / count_o <= ae_thresh_i
//   count_o                 occupancy 0..DEPTH
//   overflow_o/underflow_o  one-cycle pulse per rejected write / read
//   err_o                   sticky OR of the pulses
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = ptr_width(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 res_i,
    input  logic                 wr_en_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 rd_en_i,
    input  logic                 flush_i,
    input  logic                 clr_err_i,
    input  logic [PTR_WIDTH:0]   af_thresh_i,
    input  logic [PTR_WIDTH:0]   ae_thresh_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o,
    output logic [PTR_WIDTH:0]   count_o,
    output logic                 overflow_o,
    output logic                 underflow_o,
    output logic                 err_o
);

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("sync_fifo_prog: DEPTH must be a power of two >= 2");
    end

    localparam logic [PTR_WIDTH:0] ONE       = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);

    logic [PTR_WIDTH:0] wptr;
    logic [PTR_WIDTH:0] rptr;
    logic [PTR_WIDTH:0] count;
    logic [PTR_WIDTH:0] count_next;
    logic               full;
    logic               empty;
    logic               overflow;
    logic               underflow;
    logic               err;
    logic               rd_acc;
    logic               wr_acc;
    logic               rd_rej;
    logic               wr_rej;
    fifo_op_e           op;
    logic [WIDTH-1:0]   ram_rdata;
    logic [WIDTH-1:0]   rdata_q;

    // Acceptance. A read can make room for a write at full, but a write can
    // never satisfy a read from empty. Flush suppresses both and their errors.
    always_comb begin
        rd_acc = rd_en_i && !empty && !flush_i;
        wr_acc = wr_en_i && (!full || rd_acc) && !flush_i;
        rd_rej = rd_en_i && empty && !flush_i;
        wr_rej = wr_en_i && !wr_acc && !flush_i;
        op     = fifo_op_e'({wr_acc, rd_acc});
    end

    always_comb begin
        count_next = count;
        if (flush_i) begin
            count_next = '0;
        end else begin
            unique case (op)
                OP_PUSH: count_next = count + ONE;
                OP_POP:  count_next = count - ONE;
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            full      <= RST_FULL;
            empty     <= RST_EMPTY;
            overflow  <= RST_PULSE;
            underflow <= RST_PULSE;
            err       <= RST_ERR;
        end else begin
            overflow  <= wr_rej;
            underflow <= rd_rej;
            if (flush_i) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_acc) wptr <= wptr + ONE;
                if (rd_acc) rptr <= rptr + ONE;
            end
            count <= count_next;
            full  <= (count_next == DEPTH_CNT);
            empty <= (count_next == '0);
            // Flush leaves the sticky error untouched, including a clear.
            if (wr_rej || rd_rej) begin
                err <= 1'b1;
            end else if (clr_err_i && !flush_i) begin
                err <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_WIDTH)
    ) u_ram (
        .clk     (clk_i),
        .wr_en   (wr_acc),
        .wr_addr (wptr[PTR_WIDTH-1:0]),
        .wr_data (wdata_i),
        .rd_addr (rptr[PTR_WIDTH-1:0]),
        .rd_data (ram_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // The head entry is shown straight from the array while non-empty;
    // rdata_q tracks the shown word so it can be held once the FIFO drains
    // or is flushed.
    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            rdata_q <= '0;
        end else if (!empty) begin
            rdata_q <= ram_rdata;
        end
    end

    assign rdata_o = empty ? rdata_q : ram_rdata;
`else
    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            rdata_q <= '0;
        end else if (rd_acc) begin
            rdata_q <= ram_rdata;
        end
    end

    assign rdata_o = rdata_q;
`endif

    assign full_o         = full;
    assign empty_o        = empty;
    assign count_o        = count;
    assign overflow_o     = overflow;
    assign underflow_o    = underflow;
    assign err_o          = err;
    assign almost_full_o  = (count >= af_thresh_i);
    assign almost_empty_o = (count <= ae_thresh_i);

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: directed and randomized steps
// checked every cycle against a queue-based model of the FIFO.
module tb_sync_fifo_prog;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int PW    = 4;

    logic             clk_i = 1'b0;
    logic             res_i;
    logic             wr_en_i = 1'b0;
    logic [WIDTH-1:0] wdata_i = '0;
    logic             rd_en_i = 1'b0;
    logic             flush_i = 1'b0;
    logic             clr_err_i = 1'b0;
    logic [PW:0]      af_thresh_i = 5'd12;
    logic [PW:0]      ae_thresh_i = 5'd3;
    logic [WIDTH-1:0] rdata_o;
    logic             full_o, empty_o, almost_full_o, almost_empty_o;
    logic [PW:0]      count_o;
    logic             overflow_o, underflow_o, err_o;

    sync_fifo_prog #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .res_i          (res_i),
        .wr_en_i        (wr_en_i),
        .wdata_i        (wdata_i),
        .rd_en_i        (rd_en_i),
        .flush_i        (flush_i),
        .clr_err_i      (clr_err_i),
        .af_thresh_i    (af_thresh_i),
        .ae_thresh_i    (ae_thresh_i),
        .rdata_o        (rdata_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_rdata;
    bit               exp_ovf, exp_unf, exp_err;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".rdata"}, 32'(rdata_o), 32'(exp_rdata));
        chk({tag, ".count"}, 32'(count_o), n);
        chk({tag, ".full"},  32'(full_o),  32'(n == DEPTH));
        chk({tag, ".empty"}, 32'(empty_o), 32'(n == 0));
        chk({tag, ".afull"}, 32'(almost_full_o),  32'(n >= int'(af_thresh_i)));
        chk({tag, ".aempty"},32'(almost_empty_o), 32'(n <= int'(ae_thresh_i)));
        chk({tag, ".ovf"},   32'(overflow_o),  32'(exp_ovf));
        chk({tag, ".unf"},   32'(underflow_o), 32'(exp_unf));
        chk({tag, ".err"},   32'(err_o),       32'(exp_err));
    endtask

    // One clock cycle: drive, advance the model, clock, check.
    task automatic step(input string tag, input bit wr, input logic [WIDTH-1:0] wd,
                        input bit rd, input bit fl, input bit clr);
        int n;
        bit rd_ok, wr_ok;
        wr_en_i = wr; wdata_i = wd; rd_en_i = rd; flush_i = fl; clr_err_i = clr;
        n     = q.size();
        rd_ok = rd && (n > 0);
        wr_ok = wr && ((n < DEPTH) || rd_ok);
        if (fl) begin
            q.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            exp_ovf = wr && !wr_ok;
            exp_unf = rd && !rd_ok;
            if (rd_ok) begin
`ifdef SYNC_FIFO_FWFT_EN
                q.delete(0);
`else
                exp_rdata = q.pop_front();
`endif
            end
            if (wr_ok) q.push_back(wd);
            if (exp_ovf || exp_unf) exp_err = 1'b1;
            else if (clr)           exp_err = 1'b0;
        end
`ifdef SYNC_FIFO_FWFT_EN
        if (q.size() > 0) exp_rdata = q[0];
`endif
        @(posedge clk_i);
        #1;
        check_all(tag);
        wr_en_i = 1'b0; rd_en_i = 1'b0; flush_i = 1'b0; clr_err_i = 1'b0;
    endtask

    // Reset asserted between edges, optionally with requests in flight.
    task automatic do_reset(input string tag, input bit busy);
        wr_en_i = busy; rd_en_i = busy; wdata_i = 8'hA5;
        res_i = 1'b1;
        q.delete();
        exp_rdata = '0; exp_ovf = 1'b0; exp_unf = 1'b0; exp_err = 1'b0;
        #2;
        check_all({tag, ".during"});
        wr_en_i = 1'b0; rd_en_i = 1'b0;
        @(negedge clk_i);
        res_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_all({tag, ".after"});
    endtask

    initial begin
        do_reset("rst", 1'b0);

        // Five writes then five reads
        for (int i = 0; i < 5; i++) step("wr5", 1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("rd5", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Fill, overflow, drain (thresholds 12/3 checked each cycle)
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        step("ovf", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        step("ovf2", 1'b1, 8'hEF, 1'b0, 1'b0, 1'b0);
        step("ovf_end", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Underflow then clear; clear coinciding with an error keeps it set
        step("unf", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("unf_clr", 1'b0, '0, 1'b1, 1'b0, 1'b1);
        step("clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Write into empty with a simultaneous read: read must be rejected
        step("wr_rd_empty", 1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
        step("clr2", 1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Simultaneous read/write at full, then random mixed traffic
        for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("full_rw", 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++)
            step("mix", 1'($urandom), 8'($urandom), 1'($urandom), 1'b0,
                 ($urandom_range(0, 7) == 0));

        // Flush at count 7 with a simultaneous write
        step("pre_flush", 1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step("fill7", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        step("flush", 1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        step("post_flush", 1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
        step("post_flush_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Random traffic with random thresholds
        for (int i = 0; i < 60; i++) begin
            af_thresh_i = 5'($urandom_range(0, DEPTH));
            ae_thresh_i = 5'($urandom_range(0, DEPTH));
            step("rand", ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0));
        end
        af_thresh_i = 5'd12;
        ae_thresh_i = 5'd3;

        // Reset mid-burst
        for (int i = 0; i < 6; i++) step("burst", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        step("burst_ovf_err", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        do_reset("midrst", 1'b1);
        step("post_rst_wr", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        step("post_rst_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
